// File: rtl/mult_arbiter_64bit.sv
// rtl/mult_arbiter_64bit.sv - two-port round-robin arbiter sequencing a shared multicycle 64x64 multiplier
module mult_arbiter_64bit #(
  parameter int MULT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [63:0]  req0_a,
  input  logic [63:0]  req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [63:0]  req1_a,
  input  logic [63:0]  req1_b,
  output logic [63:0]  mul_a,
  output logic [63:0]  mul_b,
  input  logic [127:0] mul_p,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_product,
  output logic         busy
);

  localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       id;
  logic       last_id;
  logic       grant_valid;
  logic       grant_id;
  logic       accept;
  logic       capture;
  logic       handshake;

  // Under contention the requester that did not win last time is favoured.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = rst && (state == IDLE) && grant_valid && !grant_id;
  assign req1_ready = rst && (state == IDLE) && grant_valid && grant_id;
  assign accept     = req0_ready | req1_ready;
  assign capture    = (state == COMPUTE) && (cnt == 4'd0);
  assign handshake  = (state == RESPOND) && rsp_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (cnt == 4'd0) state_next = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are only loaded on accept so the multiplier sees stable inputs for the whole window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      id      <= 1'b0;
      last_id <= 1'b1;
      cnt     <= '0;
    end else if (accept) begin
      mul_a   <= grant_id ? req1_a : req0_a;
      mul_b   <= grant_id ? req1_b : req0_b;
      id      <= grant_id;
      last_id <= grant_id;
      cnt     <= CNT_INIT;
    end else if ((state == COMPUTE) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid   <= 1'b0;
      rsp_product <= '0;
      rsp_id      <= 1'b0;
    end else if (capture) begin
      rsp_valid   <= 1'b1;
      rsp_product <= mul_p;
      rsp_id      <= id;
    end else if (handshake) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule
